ib_mul_qs_pipe: RTL and testbench

- Parametrised, pipelined quarter-square multiplier: c = ((a+b)^2 - (a-b)^2) >> 2.
- Generalises the combinational 8x8 unsigned quarter-square multiplier in several ways:
  - configurable operand width;
  - per-transaction signed/unsigned mode;
  - valid/ready handshake with backpressure;
  - a sideband tag carried with each transaction.
- Sits in the ib_mul family as the registered, throughput-oriented variant used for benchmarking against the combinational versions.

---
 rtl/ib_mul_pkg.sv | 18 +
 rtl/ib_mul_qs_pipe_if.sv | 27 ++
 rtl/ib_sq_u.sv | 9 +
 rtl/ib_mul_qs_pipe.sv | 88 ++++++++
 tb/tb_ib_mul_qs_pipe.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ib_mul_pkg.sv
// Shared definitions for the ib_mul multiplier family: width helpers and the
// per-stage control sideband that travels alongside each transaction.
package ib_mul_pkg;

  function automatic int res_w(input int w);
    return 2 * w;
  endfunction

  function automatic int s1_w(input int w);
    return w + 1;
  endfunction

  typedef struct packed {
    logic vld;
    logic sgn;
  } sb_t;

endpackage

// File: rtl/ib_mul_qs_pipe_if.sv
// Operand/result handshake bundle for the pipelined quarter-square multiplier.
interface ib_mul_qs_pipe_if #(
  parameter int W     = 8,
  parameter int TAG_W = 4
);
  logic             i_valid;
  logic             o_ready;
  logic [W-1:0]     i_a;
  logic [W-1:0]     i_b;
  logic             i_signed;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [2*W-1:0]   o_c;
  logic [TAG_W-1:0] o_tag;
  logic             o_signed;

  modport slave (
    input  i_valid, i_a, i_b, i_signed, i_tag, i_ready,
    output o_ready, o_valid, o_c, o_tag, o_signed
  );

  modport master (
    output i_valid, i_a, i_b, i_signed, i_tag, i_ready,
    input  o_ready, o_valid, o_c, o_tag, o_signed
  );
endinterface

// File: rtl/ib_sq_u.sv
// Unsigned squarer: y = x * x, full 2N-bit result.
module ib_sq_u #(
  parameter int N = 9
) (
  input  logic [N-1:0]   x,
  output logic [2*N-1:0] y
);
  assign y = {{N{1'b0}}, x} * {{N{1'b0}}, x};
endmodule

// File: rtl/ib_mul_qs_pipe.sv
// Three-stage quarter-square multiplier, c = ((a+b)^2 - (a-b)^2) >> 2, with a
// valid/ready handshake; the whole pipeline freezes while the output stalls.
module ib_mul_qs_pipe
  import ib_mul_pkg::*;
#(
  parameter int W     = 8,
  parameter int TAG_W = 4
) (
  input logic             i_clk,
  input logic             i_nrst,
  ib_mul_qs_pipe_if.slave bus
);
  localparam int SW = s1_w(W);
  localparam int RW = res_w(W);

  function automatic logic [SW-1:0] ext(input logic [W-1:0] v, input logic is_sgn);
    return {is_sgn & v[W-1], v};
  endfunction

  // Negating -2^W in SW bits yields 2^W, which is the correct magnitude.
  function automatic logic [SW-1:0] mag(input logic [SW-1:0] v, input logic is_sgn);
    return (is_sgn && v[SW-1]) ? -v : v;
  endfunction

  // The squares agree mod 4, so dropping the two LSBs of the difference is exact.
  function automatic logic [RW-1:0] qs_fin(input logic [2*SW-1:0] sq_s,
                                           input logic [2*SW-1:0] sq_d);
    logic [2*SW-1:0] diff;
    diff = sq_s - sq_d;
    return diff[2*SW-1:2];
  endfunction

  logic                 en;
  sb_t                  sb_p0, sb_p1, sb_p2;
  logic [TAG_W-1:0]     tag_p0, tag_p1, tag_p2;
  logic [SW-1:0]        s_p0;
  logic signed [SW-1:0] d_p0;
  logic [SW-1:0]        mag_s, mag_d;
  logic [2*SW-1:0]      sq_s, sq_d;
  logic [2*SW-1:0]      sq_s_p1, sq_d_p1;
  logic signed [RW-1:0] c_p2;

  assign en = ~sb_p2.vld | bus.i_ready;

  // s is a signed quantity only in signed mode; d is always signed.
  assign mag_s = mag(s_p0, sb_p0.sgn);
  assign mag_d = mag(d_p0, 1'b1);

  ib_sq_u #(.N(SW)) u_sq_s (.x(mag_s), .y(sq_s));
  ib_sq_u #(.N(SW)) u_sq_d (.x(mag_d), .y(sq_d));

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      sb_p0   <= '0;
      sb_p1   <= '0;
      sb_p2   <= '0;
      tag_p0  <= '0;
      tag_p1  <= '0;
      tag_p2  <= '0;
      s_p0    <= '0;
      d_p0    <= '0;
      sq_s_p1 <= '0;
      sq_d_p1 <= '0;
      c_p2    <= '0;
    end else if (en) begin
      // S1: sum and difference of extended operands
      sb_p0   <= '{vld: bus.i_valid, sgn: bus.i_signed};
      tag_p0  <= bus.i_tag;
      s_p0    <= ext(bus.i_a, bus.i_signed) + ext(bus.i_b, bus.i_signed);
      d_p0    <= ext(bus.i_a, bus.i_signed) - ext(bus.i_b, bus.i_signed);
      // S2: squares of magnitudes
      sb_p1   <= sb_p0;
      tag_p1  <= tag_p0;
      sq_s_p1 <= sq_s;
      sq_d_p1 <= sq_d;
      // S3: quarter of the difference
      sb_p2   <= sb_p1;
      tag_p2  <= tag_p1;
      c_p2    <= qs_fin(sq_s_p1, sq_d_p1);
    end
  end

  assign bus.o_ready  = en;
  assign bus.o_valid  = sb_p2.vld;
  assign bus.o_c      = c_p2;
  assign bus.o_tag    = tag_p2;
  assign bus.o_signed = sb_p2.sgn;
endmodule

// File: tb/tb_ib_mul_qs_pipe.sv
// Bench for ib_mul_qs_pipe: directed vectors at W=8 plus an exhaustive W=4 sweep
// under random backpressure, with an in-order scoreboard on each instance.
module tb_ib_mul_qs_pipe;
  localparam int W  = 8;
  localparam int W4 = 4;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  ib_mul_qs_pipe_if #(.W(W),  .TAG_W(TW)) bus8 ();
  ib_mul_qs_pipe_if #(.W(W4), .TAG_W(TW)) bus4 ();

  ib_mul_qs_pipe #(.W(W),  .TAG_W(TW)) dut8 (.i_clk(clk), .i_nrst(nrst), .bus(bus8.slave));
  ib_mul_qs_pipe #(.W(W4), .TAG_W(TW)) dut4 (.i_clk(clk), .i_nrst(nrst), .bus(bus4.slave));

  int n_chk  = 0;
  int n_fail = 0;
  int n_out8 = 0;
  int n_out4 = 0;

  typedef struct {
    logic [63:0]   c;
    logic [TW-1:0] tag;
    logic          sgn;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  exp_t e8, e4;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product, reduced to 2w bits (two's complement when signed).
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic sgn);
    longint av, bv, p;
    av = longint'(a);
    bv = longint'(b);
    if (sgn && a[w-1]) av = av - (longint'(1) << w);
    if (sgn && b[w-1]) bv = bv - (longint'(1) << w);
    p = av * bv;
    return 64'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  always @(negedge clk) begin
    if (!nrst) q8.delete();
    else begin
      if (bus8.o_valid && bus8.i_ready) begin
        if (q8.size() == 0) check("sb8_extra", 64'd1, 64'd0);
        else begin
          e8 = q8.pop_front();
          check("sb8_c",   64'(bus8.o_c),      e8.c);
          check("sb8_tag", 64'(bus8.o_tag),    64'(e8.tag));
          check("sb8_sgn", 64'(bus8.o_signed), 64'(e8.sgn));
          n_out8++;
        end
      end
      if (bus8.i_valid && bus8.o_ready)
        q8.push_back('{c: ref_mul(W, 32'(bus8.i_a), 32'(bus8.i_b), bus8.i_signed),
                       tag: bus8.i_tag, sgn: bus8.i_signed});
    end
  end

  always @(negedge clk) begin
    if (!nrst) q4.delete();
    else begin
      if (bus4.o_valid && bus4.i_ready) begin
        if (q4.size() == 0) check("sb4_extra", 64'd1, 64'd0);
        else begin
          e4 = q4.pop_front();
          check("sb4_c",   64'(bus4.o_c),      e4.c);
          check("sb4_tag", 64'(bus4.o_tag),    64'(e4.tag));
          check("sb4_sgn", 64'(bus4.o_signed), 64'(e4.sgn));
          n_out4++;
        end
      end
      if (bus4.i_valid && bus4.o_ready)
        q4.push_back('{c: ref_mul(W4, 32'(bus4.i_a), 32'(bus4.i_b), bus4.i_signed),
                       tag: bus4.i_tag, sgn: bus4.i_signed});
    end
  end

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                        input logic [3:0] tag);
    bus8.i_valid  = 1'b1;
    bus8.i_a      = a;
    bus8.i_b      = b;
    bus8.i_signed = sgn;
    bus8.i_tag    = tag;
  endtask

  // Single transaction into an empty pipe; result must appear exactly 3 cycles later.
  task automatic one_shot(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic sgn, input logic [3:0] tag, input logic [15:0] exp);
    bus8.i_ready = 1'b1;
    drive8(a, b, sgn, tag);
    @(posedge clk); #1;
    bus8.i_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) check({nm, "_early"}, 64'(bus8.o_valid), 64'd0);
      else begin
        check({nm, "_vld"}, 64'(bus8.o_valid), 64'd1);
        check({nm, "_c"},   64'(bus8.o_c),     64'(exp));
        check({nm, "_tag"}, 64'(bus8.o_tag),   64'(tag));
        check({nm, "_sgn"}, 64'(bus8.o_signed), 64'(sgn));
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  base;
    int  guard;
    bit  acc;
    nrst = 1'b0;
    bus8.i_valid = 1'b0; bus8.i_a = '0; bus8.i_b = '0; bus8.i_signed = 1'b0;
    bus8.i_tag = '0; bus8.i_ready = 1'b1;
    bus4.i_valid = 1'b0; bus4.i_a = '0; bus4.i_b = '0; bus4.i_signed = 1'b0;
    bus4.i_tag = '0; bus4.i_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vld",   64'(bus8.o_valid),  64'd0);
    check("rst_c",     64'(bus8.o_c),      64'd0);
    check("rst_tag",   64'(bus8.o_tag),    64'd0);
    check("rst_sgn",   64'(bus8.o_signed), 64'd0);
    check("rst_rdy",   64'(bus8.o_ready),  64'd1);
    check("rst4_vld",  64'(bus4.o_valid),  64'd0);
    @(posedge clk); #1;
    nrst = 1'b1;

    one_shot("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 4'd1, 16'hFE01);
    one_shot("u_0_200", 8'd0,  8'd200, 1'b0, 4'd2, 16'h0000);
    one_shot("s_80_80", 8'h80, 8'h80, 1'b1, 4'd3, 16'h4000);
    one_shot("s_80_7f", 8'h80, 8'h7F, 1'b1, 4'd4, 16'hC080);
    one_shot("s_ff_02", 8'hFF, 8'h02, 1'b1, 4'd5, 16'hFFFE);

    base = n_out8;
    for (int i = 0; i < 16; i++) begin
      drive8(8'(i * 17 + 3), 8'(255 - i * 13), i[0], 4'(i));
      @(posedge clk); #1;
    end
    bus8.i_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stream_cnt", 64'(n_out8 - base), 64'd16);
    @(posedge clk); #1;

    // Fill the pipe with the output stalled, then hold for 5 cycles.
    base = n_out8;
    bus8.i_ready = 1'b0;
    drive8(8'd10,  8'd20,  1'b0, 4'd1); @(posedge clk); #1;
    drive8(8'hF6,  8'd3,   1'b1, 4'd2); @(posedge clk); #1;
    drive8(8'd100, 8'd100, 1'b0, 4'd3); @(posedge clk); #1;
    drive8(8'd7,   8'd9,   1'b0, 4'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_rdy", 64'(bus8.o_ready), 64'd0);
      check("stall_vld", 64'(bus8.o_valid), 64'd1);
      check("stall_c",   64'(bus8.o_c),     64'h00C8);
      check("stall_tag", 64'(bus8.o_tag),   64'd1);
      @(posedge clk); #1;
    end
    bus8.i_ready = 1'b1;
    @(posedge clk); #1;
    bus8.i_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("drain_cnt", 64'(n_out8 - base), 64'd4);
    check("drain_q",   64'(q8.size()),     64'd0);
    @(posedge clk); #1;

    // Reset with three transactions in flight.
    base = n_out8;
    for (int i = 0; i < 3; i++) begin
      drive8(8'(i + 20), 8'(i + 30), 1'b0, 4'(i + 5));
      @(posedge clk); #1;
    end
    bus8.i_valid = 1'b0;
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    check("mrst_vld", 64'(bus8.o_valid), 64'd0);
    check("mrst_c",   64'(bus8.o_c),     64'd0);
    check("mrst_rdy", 64'(bus8.o_ready), 64'd1);
    repeat (6) begin
      @(negedge clk);
      check("mrst_stale", 64'(bus8.o_valid), 64'd0);
    end
    check("mrst_cnt", 64'(n_out8 - base), 64'd0);
    @(posedge clk); #1;

    // Exhaustive W=4 sweep, both modes, random output backpressure.
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          bus4.i_valid  = 1'b1;
          bus4.i_a      = 4'(a);
          bus4.i_b      = 4'(b);
          bus4.i_signed = s[0];
          bus4.i_tag    = 4'(b);
          guard = 0;
          acc   = 1'b0;
          while (!acc && guard < 64) begin
            bus4.i_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus4.o_ready;
            @(posedge clk); #1;
            guard++;
          end
          if (!acc) check("sweep_stuck", 64'd0, 64'd1);
        end
    bus4.i_valid = 1'b0;
    bus4.i_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("sweep_cnt", 64'(n_out4),    64'd512);
    check("sweep_q",   64'(q4.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
